// File: rtl/axis_width_upsizer_pkg.sv
// Shared types and defaults for the AXIS width upsizer.
// Holds the packing FSM encoding and the lane-index width helper.
package axis_upsizer_pkg;

  typedef enum logic [1:0] {
    FILL,
    PART,
    STALL
  } up_state_t;

  localparam int DEF_IN_WIDTH = 16;
  localparam int DEF_RATIO    = 8;

  function automatic int lane_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/axis_width_upsizer_if.sv
// AXI-Stream data/valid/ready bundle.
// Master drives tdata/tvalid, slave drives tready.
interface axis_width_upsizer_if #(
  parameter int W = 16
);

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_width_upsizer_out_stage.sv
// Output word register for the upsizer.
// Holds the packed word stable until the downstream FIFO takes it.
module axis_out_stage #(
  parameter int W = 128
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         busy,
  axis_width_upsizer_if.master out_bus
);

  logic [W-1:0] data_q;
  logic         vld_q;

  always_ff @(posedge aclk) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (load) begin
      data_q <= load_data;
      vld_q  <= 1'b1;
    end else if (vld_q && out_bus.tready) begin
      vld_q  <= 1'b0;
    end
  end

  assign out_bus.tdata  = data_q;
  assign out_bus.tvalid = vld_q;
  assign busy           = vld_q;

endmodule

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow AXIS beats into one wide word for the MIG FIFO.
// Optional idle flush of partial words: AXIS_UPSIZER_FLUSH_EN.
module axis_width_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int IN_WIDTH      = DEF_IN_WIDTH,
  parameter int RATIO         = DEF_RATIO,
  parameter int OUT_WIDTH     = IN_WIDTH * RATIO,
  parameter int FLUSH_TIMEOUT = 256,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic aclk,
  input  logic reset,
  axis_width_upsizer_if.slave  in_bus,
  axis_width_upsizer_if.master out_bus
);

  localparam int CW = lane_idx_w(RATIO);
  localparam int LW = OUT_WIDTH - IN_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic                 reset_q;
  up_state_t            state_q;
  up_state_t            state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] acc_d;
  logic [OUT_WIDTH-1:0] load_word;
  logic [OUT_WIDTH-1:0] pad_word;
  logic                 load;
  logic                 vld_d;
  logic                 out_busy;
  logic                 in_rdy;
  logic                 accept;
  logic                 flush_go;

`ifdef AXIS_UPSIZER_FLUSH_EN
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(FLUSH_TIMEOUT);

  logic [TW-1:0] idle_q;

  // Saturates at the timeout so a flush blocked by a held word waits.
  assign flush_go = (idle_q == TMO) && (cnt_q != '0) && !out_busy;

  always_ff @(posedge aclk) begin
    if (reset) begin
      idle_q <= '0;
    end else if (flush_go || cnt_q == '0 || accept) begin
      idle_q <= '0;
    end else if (idle_q != TMO) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  always_comb begin
    pad_word = '0;
    for (int j = 0; j < RATIO; j++) begin
      pad_word[j*IN_WIDTH +: IN_WIDTH] =
        (j < int'(cnt_q)) ? acc_q[j*IN_WIDTH +: IN_WIDTH] : PAD_VALUE;
    end
  end
`else
  assign flush_go = 1'b0;
  assign pad_word = acc_q;
`endif

  always_ff @(posedge aclk) begin
    if (reset) begin
      reset_q <= 1'b1;
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      reset_q <= 1'b0;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    load      = 1'b0;
    load_word = pad_word;
    if (flush_go) begin
      load  = 1'b1;
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == LAST) begin
        load      = 1'b1;
        load_word = {in_bus.tdata, acc_q[LW-1:0]};
        cnt_d     = '0;
      end else begin
        acc_d[int'(cnt_q)*IN_WIDTH +: IN_WIDTH] = in_bus.tdata;
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Mirrors the output register so STALL tracks its valid bit.
    vld_d = load | (out_busy & ~out_bus.tready);
    unique case (1'b1)
      (cnt_d == '0):           state_d = FILL;
      (cnt_d == LAST && vld_d): state_d = STALL;
      default:                 state_d = PART;
    endcase
  end

  always_comb begin
    in_rdy = !reset_q && (state_q != STALL) && !flush_go;
    accept = in_bus.tvalid && in_rdy;
  end

  assign in_bus.tready = in_rdy;

  axis_out_stage #(
    .W(OUT_WIDTH)
  ) u_out (
    .aclk     (aclk),
    .reset    (reset),
    .load     (load),
    .load_data(load_word),
    .busy     (out_busy),
    .out_bus  (out_bus)
  );

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Scoreboard bench for axis_width_upsizer (16-bit beats, RATIO 8).
// Expected words are queued by the stimulus and checked by a monitor.
module tb_axis_width_upsizer;

  localparam int IW = 16;
  localparam int R  = 8;
  localparam int OW = IW * R;
  localparam logic [IW-1:0] PAD = 16'hA5A5;

  logic aclk = 1'b0;
  logic reset = 1'b1;

  axis_width_upsizer_if #(.W(IW)) in_bus ();
  axis_width_upsizer_if #(.W(OW)) out_bus ();

  axis_width_upsizer #(
    .IN_WIDTH     (IW),
    .RATIO        (R),
    .FLUSH_TIMEOUT(4),
    .PAD_VALUE    (PAD)
  ) dut (
    .aclk   (aclk),
    .reset  (reset),
    .in_bus (in_bus),
    .out_bus(out_bus)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int ready_low = 0;
  logic [OW-1:0] sb[$];
  bit hold_prev = 1'b0;
  logic [OW-1:0] prev_data;

  task automatic chk(input string name, input logic [OW-1:0] act,
                     input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] d);
    int n;
    in_bus.tvalid = 1'b1;
    in_bus.tdata  = d;
    n = 0;
    while (!in_bus.tready && n < 100) begin
      step();
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_tready want in_tready for %h", d);
    end
    step();
  endtask

  task automatic idle();
    in_bus.tvalid = 1'b0;
  endtask

  function automatic logic [OW-1:0] word_of(input logic [IW-1:0] base);
    logic [OW-1:0] w;
    for (int k = 0; k < R; k++) w[k*IW +: IW] = base + IW'(k);
    return w;
  endfunction

  always @(negedge aclk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (in_bus.tvalid && !in_bus.tready) ready_low++;
      if (out_bus.tvalid) begin
        if (hold_prev) chk("hold_stable", out_bus.tdata, prev_data);
        if (out_bus.tready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h want none", out_bus.tdata);
          end else begin
            chk("word", out_bus.tdata, sb.pop_front());
          end
          hold_prev = 1'b0;
        end else begin
          hold_prev = 1'b1;
          prev_data = out_bus.tdata;
        end
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_bus.tvalid  = 1'b0;
    in_bus.tdata   = '0;
    out_bus.tready = 1'b0;
    reset = 1'b1;
    step();
    step();
    chk("rst_in_tready", OW'(in_bus.tready), '0);
    chk("rst_out_tvalid", OW'(out_bus.tvalid), '0);
    chk("rst_out_tdata", out_bus.tdata, '0);
    reset = 1'b0;
    chk("rst_q_in_tready", OW'(in_bus.tready), '0);
    step();
    chk("post_rst_in_tready", OW'(in_bus.tready), OW'(1));

    // Single word 0x0001..0x0008
    out_bus.tready = 1'b1;
    ready_low = 0;
    sb.push_back(128'h0008_0007_0006_0005_0004_0003_0002_0001);
    for (int i = 1; i <= 8; i++) begin
      send(IW'(i));
      if (i == 7) chk("lat_before", OW'(out_bus.tvalid), '0);
      if (i == 8) chk("lat_after", OW'(out_bus.tvalid), OW'(1));
    end
    idle();
    repeat (3) step();

    // 64 continuous beats
    for (int w = 0; w < 8; w++) sb.push_back(word_of(IW'(16'h1000 + w * 8)));
    for (int i = 0; i < 64; i++) send(IW'(16'h1000 + i));
    idle();
    repeat (3) step();
    chk("stream_no_stall", OW'(ready_low), '0);
    chk("stream_drained", OW'(sb.size()), '0);

    // Backpressure: 16 beats with out_tready low
    out_bus.tready = 1'b0;
    sb.push_back(word_of(16'h2000));
    sb.push_back(word_of(16'h2008));
    for (int i = 0; i < 15; i++) send(IW'(16'h2000 + i));
    in_bus.tvalid = 1'b1;
    in_bus.tdata  = 16'h200F;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_tready_low", OW'(in_bus.tready), '0);
    end
    chk("bp_held_valid", OW'(out_bus.tvalid), OW'(1));
    chk("bp_held_data", out_bus.tdata, word_of(16'h2000));
    out_bus.tready = 1'b1;
    send(16'h200F);
    idle();
    repeat (4) step();
    chk("bp_drained", OW'(sb.size()), '0);

    // Reset after 5 beats of a partial word
    for (int i = 0; i < 5; i++) send(IW'(16'hDE00 + i));
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    sb.push_back(word_of(16'h3000));
    for (int i = 0; i < 8; i++) send(IW'(16'h3000 + i));
    idle();
    repeat (3) step();
    chk("rst_part_drained", OW'(sb.size()), '0);

    // Reset while a full word is held
    out_bus.tready = 1'b0;
    for (int i = 0; i < 8; i++) send(IW'(16'h4000 + i));
    idle();
    step();
    chk("held_before_rst", OW'(out_bus.tvalid), OW'(1));
    reset = 1'b1;
    step();
    chk("rst_held_valid", OW'(out_bus.tvalid), '0);
    chk("rst_held_data", out_bus.tdata, '0);
    step();
    reset = 1'b0;
    step();
    step();
    out_bus.tready = 1'b1;
    repeat (3) step();
    sb.push_back(word_of(16'h5000));
    for (int i = 0; i < 8; i++) send(IW'(16'h5000 + i));
    idle();
    repeat (3) step();
    chk("rst_held_drained", OW'(sb.size()), '0);

    // Partial word followed by idle
`ifdef AXIS_UPSIZER_FLUSH_EN
    sb.push_back({PAD, PAD, PAD, PAD, PAD, 16'h6003, 16'h6002, 16'h6001});
`endif
    for (int i = 1; i <= 3; i++) send(IW'(16'h6000 + i));
    idle();
    for (int n = 0; n < 4; n++) begin
      step();
      chk("flush_wait", OW'(out_bus.tvalid), '0);
    end
    step();
`ifdef AXIS_UPSIZER_FLUSH_EN
    chk("flush_fire", OW'(out_bus.tvalid), OW'(1));
`else
    chk("no_flush", OW'(out_bus.tvalid), '0);
`endif
    repeat (10) step();
    chk("final_valid", OW'(out_bus.tvalid), '0);
    chk("sb_empty", OW'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
